// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SERVE_IF = 2'd1,
        ST_SERVE_DM = 2'd2
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEFAULT      = 255;
    localparam int ARB_STARVE_LIMIT_DEFAULT = 4;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Wait-cycle counter for an in-flight memory transaction. Counts cycles
// spent waiting for mem_valid and flags when the count reaches TIMEOUT.
module arb_timeout_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_wait,
    output logic o_expired
);

    localparam int              CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Clear while no transaction is in flight, count wait cycles otherwise;
    // hold at the terminal value so the count can never wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_wait && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between an instruction-fetch requester
// and a data requester. Data wins ties unless fetch has been passed over
// STARVE_LIMIT times in a row; stalled transactions abort after TIMEOUT
// wait cycles with an error completion.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ST_IDLE     | no transaction in flight; arbitrate pending requests
//   ST_SERVE_IF | fetch transaction on the memory port, awaiting mem_valid
//   ST_SERVE_DM | data transaction on the memory port, awaiting mem_valid
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = ARB_TIMEOUT_DEFAULT,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [3:0]        if_mask,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_mask,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int              SC_W       = cnt_width(STARVE_LIMIT);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;

    logic              w_serving;
    logic              w_grant_if;
    logic              w_grant_dm;
    logic              w_done;
    logic              w_abort;
    logic              w_expired;
    logic              w_if_fin;
    logic              w_dm_fin;
    logic              w_fetch_starved;

    logic [SC_W-1:0]   r_starve;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_mask;

    logic              r_if_valid;
    logic              r_if_err;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_dm_valid;
    logic              r_dm_err;
    logic [DATA_W-1:0] r_dm_rdata;

    assign w_serving       = (r_state == ST_SERVE_IF) || (r_state == ST_SERVE_DM);
    assign w_fetch_starved = if_req && (r_starve == STARVE_MAX);
    assign w_if_fin        = (w_done || w_abort) && (r_state == ST_SERVE_IF);
    assign w_dm_fin        = (w_done || w_abort) && (r_state == ST_SERVE_DM);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant selection in IDLE; completion or timeout decode while serving.
    // mem_valid wins over an expiring wait count, so a response arriving on
    // the last allowed cycle still completes normally.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dm_req && !w_fetch_starved) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = ST_SERVE_DM;
                end else if (if_req) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = ST_SERVE_IF;
                end
            end
            ST_SERVE_IF, ST_SERVE_DM: begin
                if (mem_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (!w_serving),
        .i_wait    (w_serving && !mem_valid),
        .o_expired (w_expired)
    );

    // Starvation tracking: counts data grants that overtook a pending fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_grant_if) begin
            r_starve <= '0;
        end else if (w_grant_dm && if_req && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SC_W'(1);
        end
    end

    // Memory port: launch the granted request and hold it until it ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
        end else if (w_grant_dm) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_mem_mask  <= dm_mask;
        end else if (w_grant_if) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_mask  <= if_mask;
        end else if (w_done || w_abort) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Requester responses: one-cycle valid pulse, read data held until the
    // same requester completes again; an aborted transaction returns zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_if_valid <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_valid <= 1'b0;
            r_dm_err   <= 1'b0;
            r_dm_rdata <= '0;
        end else begin
            r_if_valid <= w_if_fin;
            r_if_err   <= w_if_fin && w_abort;
            r_dm_valid <= w_dm_fin;
            r_dm_err   <= w_dm_fin && w_abort;
            if (w_if_fin) begin
                r_if_rdata <= w_done ? mem_rdata : '0;
            end
            if (w_dm_fin) begin
                r_dm_rdata <= w_done ? mem_rdata : '0;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_mask  = r_mem_mask;

    assign if_valid  = r_if_valid;
    assign if_err    = r_if_err;
    assign if_rdata  = r_if_rdata;
    assign dm_valid  = r_dm_valid;
    assign dm_err    = r_dm_err;
    assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized transactions compared against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int SL  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [3:0]    if_mask;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [3:0]    dm_mask;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          dm_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_mask;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;

    int            checks   = 0;
    int            failures = 0;

    // Model state: consecutive data wins over a waiting fetch, and the
    // read data each requester last received.
    int            model_starve;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_dm_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .TIMEOUT      (TMO),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_mask   (if_mask),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_mask   (dm_mask),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .dm_err    (dm_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_mask  (mem_mask),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Data wins unless fetch is also waiting and has been overtaken SL times.
    function automatic bit model_pick_dm(input bit ir, input bit dr);
        return dr && !(ir && (model_starve == SL));
    endfunction

    task automatic do_reset;
        rst       = 1'b0;
        if_req    = 1'b0;
        dm_req    = 1'b0;
        mem_valid = 1'b0;
        tick;
        tick;
        rst          = 1'b1;
        model_starve = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
    endtask

    // One complete transaction issued from IDLE. Memory answers in the k-th
    // cycle of mem_req; beyond TMO+1 cycles it never answers and the
    // transaction must abort after the TMO+1-th cycle.
    task automatic run_txn(input string tag, input bit ir, input bit dr, input bit we,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [3:0] im, input logic [3:0] dmk,
                           input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int k);
        bit            pick_dm;
        bit            to;
        int            last_j;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rd;
        logic [3:0]    exp_mask;
        if_req   = ir;
        dm_req   = dr;
        dm_we    = we;
        if_addr  = ia;
        dm_addr  = da;
        if_mask  = im;
        dm_mask  = dmk;
        dm_wdata = wd;
        pick_dm  = model_pick_dm(ir, dr);
        if (pick_dm) begin
            exp_we   = we;
            exp_addr = da;
            exp_wd   = wd;
            exp_mask = dmk;
            if (ir) model_starve = (model_starve < SL) ? model_starve + 1 : SL;
        end else begin
            exp_we       = 1'b0;
            exp_addr     = ia;
            exp_wd       = '0;
            exp_mask     = im;
            model_starve = 0;
        end
        to     = (k > TMO + 1);
        last_j = to ? TMO + 1 : k;
        tick;
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int j = 1; j <= last_j; j++) begin
            if (j > 1) tick;
            chk({tag, "_ctl"}, {mem_req, mem_we, mem_mask, if_valid, dm_valid},
                {1'b1, exp_we, exp_mask, 1'b0, 1'b0});
            chk({tag, "_addr"}, mem_addr, exp_addr);
            chk({tag, "_wdata"}, mem_wdata, exp_wd);
            mem_valid = (j == k);
            mem_rdata = (j == k) ? rd : DW'($urandom);
        end
        tick;
        mem_valid = 1'b0;
        exp_rd    = to ? '0 : rd;
        if (pick_dm) exp_dm_rdata = exp_rd;
        else         exp_if_rdata = exp_rd;
        chk({tag, "_valid"}, {if_valid, dm_valid}, pick_dm ? 2'b01 : 2'b10);
        chk({tag, "_err"}, pick_dm ? dm_err : if_err, to);
        chk({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
        chk({tag, "_dm_rdata"}, dm_rdata, exp_dm_rdata);
        chk({tag, "_req_drop"}, mem_req, 1'b0);
        tick;
        chk({tag, "_pulse_end"}, {if_valid, dm_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        if_mask   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_mask   = '0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        model_starve = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;

        // Reset state
        tick;
        tick;
        chk("rst_ctl", {mem_req, mem_we, mem_mask, if_valid, dm_valid, if_err, dm_err}, '0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_rdata", {if_rdata, dm_rdata}, '0);
        rst = 1'b1;
        tick;

        // Lone load, memory answers three cycles after mem_req rises
        run_txn("load100", 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 4'h0, 4'hF,
                32'h0, 32'hDEADBEEF, 4);

        // Store, outputs held until mem_valid
        run_txn("store20", 1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 4'h0, 4'hF,
                32'h12345678, 32'h0BADF00D, 3);

        // Fetch with data, then a fetch that times out and returns zero
        run_txn("fetch_ok", 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 4'h0,
                32'hFFFF0000, 32'hCAFEF00D, 2);
        run_txn("fetch_to", 1'b1, 1'b0, 1'b0, 32'h404, 32'h0, 4'hF, 4'h0,
                32'hFFFF0000, 32'h11111111, TMO + 5);
        chk("fetch_to_idle", {mem_req, if_valid, dm_valid}, 3'b000);

        // Response arriving on the last allowed cycle is a normal completion
        run_txn("edge_ok", 1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 4'h0, 4'h3,
                32'h0, 32'h77665544, TMO + 1);

        // Both requesters held: DM x4 then IF, repeating
        do_reset;
        if_addr = 32'h1000;
        dm_addr = 32'h2000;
        if_mask = 4'hF;
        dm_mask = 4'h3;
        dm_we   = 1'b0;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        for (int g = 0; g < 10; g++) begin
            bit exp_dm;
            for (int n = 0; n < 4 && mem_req !== 1'b1; n++) tick;
            exp_dm = (g % 5) != 4;
            chk($sformatf("starve_g%0d_req", g), mem_req, 1'b1);
            chk($sformatf("starve_g%0d_addr", g), mem_addr, exp_dm ? 32'h2000 : 32'h1000);
            mem_valid = 1'b1;
            mem_rdata = 32'hA0 + g;
            tick;
            mem_valid = 1'b0;
            chk($sformatf("starve_g%0d_valid", g), {if_valid, dm_valid}, exp_dm ? 2'b01 : 2'b10);
            if (exp_dm) exp_dm_rdata = 32'hA0 + g;
            else        exp_if_rdata = 32'hA0 + g;
            chk($sformatf("starve_g%0d_rdata", g), exp_dm ? dm_rdata : if_rdata, 32'hA0 + g);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        model_starve = 0;
        tick;
        chk("starve_release", mem_req, 1'b0);

        // Reset during a data transaction abandons it
        dm_req  = 1'b1;
        dm_addr = 32'h300;
        tick;
        chk("rstsrv_req", mem_req, 1'b1);
        dm_req = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rstsrv_drop", {mem_req, dm_valid, if_valid}, 3'b000);
        rst          = 1'b1;
        model_starve = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        mem_valid    = 1'b1;
        mem_rdata    = 32'h99999999;
        tick;
        mem_valid = 1'b0;
        chk("rstsrv_stale", {mem_req, dm_valid, if_valid}, 3'b000);
        chk("rstsrv_rdata", dm_rdata, '0);
        run_txn("rstsrv_fetch", 1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 4'hF, 4'h0,
                32'h0, 32'h5A5A1234, 2);

        // mem_valid while idle is ignored
        mem_valid = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        tick;
        mem_valid = 1'b0;
        chk("idle_mv_valid", {if_valid, dm_valid, mem_req}, 3'b000);
        chk("idle_mv_rdata", if_rdata, exp_if_rdata);
        tick;
        chk("idle_mv_stay", mem_req, 1'b0);
        run_txn("idle_mv_next", 1'b0, 1'b1, 1'b1, 32'h0, 32'h50, 4'h0, 4'h1,
                32'h00C0FFEE, 32'h12121212, 1);

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++) begin
            int p;
            p = $urandom_range(0, 2);
            run_txn($sformatf("rnd%0d", i), p != 0, p != 1, 1'($urandom),
                    AW'($urandom), AW'($urandom), 4'($urandom), 4'($urandom),
                    DW'($urandom), DW'($urandom), $urandom_range(1, TMO + 3));
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
